inter_slave_port: RTL and testbench

//  Slave-side endpoint of the two-master/two-slave inter bus. Consumes valid/addr/value
//  and handshake from the interconnect, drives ready after a programmable wait and commits

---
 rtl/inter_slave_port.sv | 91 +++++++++
 tb/tb_inter_slave_port.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/inter_slave_port.sv
// inter_slave_port: slave endpoint of the inter bus; delayed ready, commit into a local
// register file, readback, saturating write counter and sticky protocol error flags.
module inter_slave_port #(
    parameter int READY_DELAY = 2,
    parameter int ADDR_W      = 3,
    parameter int DATA_W      = 3,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] value_in,
    input  logic              handshake_in,
    output logic              ready,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err_abort,
    output logic              err_spur
);
    typedef enum logic [1:0] {IDLE, WAIT, RDY} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              commit, abort, spur;
    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: if (valid_in) begin
                state_nx = (READY_DELAY == 0) ? RDY : WAIT;
                cnt_nx   = (READY_DELAY == 0) ? 4'd0 : 4'(READY_DELAY - 1);
            end
            WAIT: if (!valid_in) begin
                state_nx = IDLE;
                abort    = 1'b1;
            end else if (cnt == 4'd0) begin
                state_nx = RDY;
            end else begin
                cnt_nx = cnt - 4'd1;
            end
            RDY: if (handshake_in) begin
                state_nx = IDLE;
                commit   = 1'b1;
            end else if (!valid_in) begin
                state_nx = IDLE;
                abort    = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign spur    = handshake_in && (state != RDY);
    // Drop ready in the handshake cycle so the interconnect never latches a stale 1.
    assign ready   = (state == RDY) && !handshake_in;
    assign rd_data = regs[rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_count  <= '0;
            err_abort <= 1'b0;
            err_spur  <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            wr_pulse  <= commit;
            err_abort <= err_abort | abort;
            err_spur  <= err_spur | spur;
            if (commit) begin
                regs[addr_in] <= value_in;
                wr_addr       <= addr_in;
                wr_data       <= value_in;
                if (!(&wr_count)) wr_count <= wr_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inter_slave_port.sv
// tb_inter_slave_port: directed checks on a default instance (delay 2) and a delay-0,
// 2-bit-counter instance.
module tb_inter_slave_port;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v = 1'b0, h = 1'b0;
    logic [2:0] a = '0, d = '0, rda = '0;
    logic       ready, wr_pulse, err_abort, err_spur;
    logic [2:0] wr_addr, wr_data, rd_data;
    logic [7:0] wr_count;
    logic       v0 = 1'b0, h0 = 1'b0;
    logic [2:0] a0 = '0, d0 = '0, rda0 = '0;
    logic       rdy0, wr_pulse0, err_abort0, err_spur0;
    logic [2:0] wr_addr0, wr_data0, rd_data0;
    logic [1:0] wr_count0;
    int         checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inter_slave_port dut (
        .clk(clk), .rst_n(rst_n), .valid_in(v), .addr_in(a), .value_in(d),
        .handshake_in(h), .ready(ready), .wr_pulse(wr_pulse), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rda), .rd_data(rd_data), .wr_count(wr_count),
        .err_abort(err_abort), .err_spur(err_spur)
    );

    inter_slave_port #(.READY_DELAY(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(v0), .addr_in(a0), .value_in(d0),
        .handshake_in(h0), .ready(rdy0), .wr_pulse(wr_pulse0), .wr_addr(wr_addr0),
        .wr_data(wr_data0), .rd_addr(rda0), .rd_data(rd_data0), .wr_count(wr_count0),
        .err_abort(err_abort0), .err_spur(err_spur0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", ready); end
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL rst_wr_pulse got %0b exp 0", wr_pulse); end
        checks++; if (wr_count !== 8'd0) begin errors++; $display("FAIL rst_wr_count got %0d exp 0", wr_count); end
        checks++; if (wr_addr !== 3'd0 || wr_data !== 3'd0) begin errors++; $display("FAIL rst_wr_addr_data got %0d/%0d exp 0/0", wr_addr, wr_data); end
        checks++; if (err_abort !== 1'b0 || err_spur !== 1'b0) begin errors++; $display("FAIL rst_errs got %0b%0b exp 00", err_abort, err_spur); end
        for (int i = 0; i < 8; i++) begin
            rda = 3'(i);
            #1;
            checks++; if (rd_data !== 3'd0) begin errors++; $display("FAIL rst_reg%0d got %0d exp 0", i, rd_data); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        tick;
        v = 1'b1; a = 3'd5; d = 3'd3;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick;
            #0;
            checks++; if (ready !== (c == 3)) begin errors++; $display("FAIL single_ready_c%0d got %0b exp %0b", c, ready, c == 3); end
        end
        tick;
        h = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_hs got %0b exp 0", ready); end
        checks++; if (wr_count !== 8'd0) begin errors++; $display("FAIL single_count_pre got %0d exp 0", wr_count); end
        tick;
        h = 1'b0; v = 1'b0; rda = 3'd5;
        #1;
        checks++; if (wr_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %0b exp 1", wr_pulse); end
        checks++; if (rd_data !== 3'd3) begin errors++; $display("FAIL single_rd got %0d exp 3", rd_data); end
        checks++; if (wr_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", wr_count); end
        checks++; if (wr_addr !== 3'd5 || wr_data !== 3'd3) begin errors++; $display("FAIL single_wr_addr_data got %0d/%0d exp 5/3", wr_addr, wr_data); end
        tick;
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %0b exp 0", wr_pulse); end
    endtask

    task automatic test_back_to_back;
        int prev;
        bit got;
        prev = 0;
        tick;
        v = 1'b1;
        for (int i = 0; i < 8; i++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                tick;
                if (ready) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++; $display("FAIL b2b_ready_%0d got timeout exp ready", i);
            end else begin
                if (i > 0) begin
                    checks++; if (cyc - prev !== 4) begin errors++; $display("FAIL b2b_spacing_%0d got %0d exp 4", i, cyc - prev); end
                end
                prev = cyc; a = 3'(i); d = 3'(7 - i); h = 1'b1;
                tick;
                h = 1'b0;
                if (i == 7) v = 1'b0;
                checks++; if (wr_pulse !== 1'b1) begin errors++; $display("FAIL b2b_pulse_%0d got %0b exp 1", i, wr_pulse); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            rda = 3'(i);
            #1;
            checks++; if (rd_data !== 3'(7 - i)) begin errors++; $display("FAIL b2b_reg%0d got %0d exp %0d", i, rd_data, 7 - i); end
        end
        checks++; if (wr_count !== 8'd9) begin errors++; $display("FAIL b2b_count got %0d exp 9", wr_count); end
    endtask

    task automatic test_abort;
        tick;
        v = 1'b1; a = 3'd6; d = 3'd0;
        tick;
        tick;
        v = 1'b0;
        #1;
        checks++; if (err_abort !== 1'b0) begin errors++; $display("FAIL abort_early got %0b exp 0", err_abort); end
        tick;
        rda = 3'd6;
        #1;
        checks++; if (err_abort !== 1'b1) begin errors++; $display("FAIL abort_flag got %0b exp 1", err_abort); end
        checks++; if (ready !== 1'b0 || wr_pulse !== 1'b0) begin errors++; $display("FAIL abort_ready_pulse got %0b%0b exp 00", ready, wr_pulse); end
        checks++; if (wr_count !== 8'd9) begin errors++; $display("FAIL abort_count got %0d exp 9", wr_count); end
        checks++; if (rd_data !== 3'd1) begin errors++; $display("FAIL abort_reg6 got %0d exp 1", rd_data); end
    endtask

    task automatic test_spurious;
        tick;
        a = 3'd2; d = 3'd0; h = 1'b1;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL spur_ready got %0b exp 0", ready); end
        tick;
        h = 1'b0; rda = 3'd2;
        #1;
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL spur_flag got %0b exp 1", err_spur); end
        checks++; if (rd_data !== 3'd5) begin errors++; $display("FAIL spur_reg2 got %0d exp 5", rd_data); end
        checks++; if (wr_count !== 8'd9 || wr_pulse !== 1'b0) begin errors++; $display("FAIL spur_count_pulse got %0d/%0b exp 9/0", wr_count, wr_pulse); end
        checks++; if (err_abort !== 1'b1) begin errors++; $display("FAIL spur_abort_sticky got %0b exp 1", err_abort); end
    endtask

    task automatic test_reset_mid;
        bit got;
        got = 1'b0;
        tick;
        v = 1'b1; a = 3'd1; d = 3'd6;
        for (int k = 0; k < 20 && !got; k++) begin
            tick;
            if (ready) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL rstmid_ready got timeout exp ready"); end
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_async got %0b exp 0", ready); end
        h = 1'b1;
        tick;
        checks++; if (wr_count !== 8'd0 || wr_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_count_pulse got %0d/%0b exp 0/0", wr_count, wr_pulse); end
        checks++; if (err_abort !== 1'b0 || err_spur !== 1'b0) begin errors++; $display("FAIL rstmid_errs got %0b%0b exp 00", err_abort, err_spur); end
        for (int i = 0; i < 8; i++) begin
            rda = 3'(i);
            #1;
            checks++; if (rd_data !== 3'd0) begin errors++; $display("FAIL rstmid_reg%0d got %0d exp 0", i, rd_data); end
        end
        h = 1'b0; v = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_delay0;
        tick;
        v0 = 1'b1; a0 = 3'd4; d0 = 3'd2;
        #1;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL d0_ready_c0 got %0b exp 0", rdy0); end
        tick;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL d0_ready_c1 got %0b exp 1", rdy0); end
        h0 = 1'b1;
        tick;
        h0 = 1'b0; v0 = 1'b0; rda0 = 3'd4;
        #1;
        checks++; if (wr_pulse0 !== 1'b1 || rd_data0 !== 3'd2) begin errors++; $display("FAIL d0_commit got %0b/%0d exp 1/2", wr_pulse0, rd_data0); end
        checks++; if (wr_count0 !== 2'd1) begin errors++; $display("FAIL d0_count got %0d exp 1", wr_count0); end
    endtask

    task automatic test_saturation;
        logic [1:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = (i == 0) ? 2'd2 : 2'd3;
            tick;
            v0 = 1'b1; a0 = 3'(i); d0 = 3'(i + 1);
            tick;
            checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL sat_ready_%0d got %0b exp 1", i, rdy0); end
            h0 = 1'b1;
            tick;
            h0 = 1'b0; v0 = 1'b0;
            #1;
            checks++; if (wr_count0 !== exp) begin errors++; $display("FAIL sat_count_%0d got %0d exp %0d", i, wr_count0, exp); end
        end
        rda0 = 3'd3;
        #1;
        checks++; if (rd_data0 !== 3'd4) begin errors++; $display("FAIL sat_reg3 got %0d exp 4", rd_data0); end
        checks++; if (err_abort0 !== 1'b0 || err_spur0 !== 1'b0) begin errors++; $display("FAIL sat_errs got %0b%0b exp 00", err_abort0, err_spur0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_write;
        test_back_to_back;
        test_abort;
        test_spurious;
        test_reset_mid;
        test_delay0;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
